mem_bus_arbiter: RTL and testbench

- Shares the byte_addressable RAM and the ASCII/VGA character-buffer write port between two requesters: the CPU core (port 0) and a debug/program loader (port 1).
- Decodes each request by address:
  - below VGA_BASE goes to RAM;
  - at or above VGA_BASE goes to the VGA write port.
- Sequences RAM read latency and the write-completion handshake, then returns a one-cycle ack to the winning requester.
- Sits between the processor FSM and the memory/VGA blocks and replaces direct CPU drive of memory_address/write_en/vga_write_en.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, RAM and VGA signal bundle for mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req0;
    logic                 req1;
    logic [WORD_SIZE-1:0] addr0;
    logic [WORD_SIZE-1:0] addr1;
    logic [1:0]           wmode0;
    logic [1:0]           wmode1;
    logic [WORD_SIZE-1:0] wdata0;
    logic [WORD_SIZE-1:0] wdata1;
    logic                 ack0;
    logic                 ack1;
    logic [WORD_SIZE-1:0] rdata;
    logic                 err;
    logic [WORD_SIZE-1:0] ram_address;
    logic [1:0]           ram_write_mode;
    logic [WORD_SIZE-1:0] ram_wdata;
    logic [WORD_SIZE-1:0] ram_rdata;
    logic                 ram_done;
    logic                 ram_align_error;
    logic                 vga_write_en;
    logic [12:0]          vga_write_address;
    logic [WORD_SIZE-1:0] vga_input_data;

    // slave: the arbiter; master: requesters plus the RAM/VGA blocks around it
    modport slave (
        input  req0, req1, addr0, addr1, wmode0, wmode1, wdata0, wdata1,
        input  ram_rdata, ram_done, ram_align_error,
        output ack0, ack1, rdata, err,
        output ram_address, ram_write_mode, ram_wdata,
        output vga_write_en, vga_write_address, vga_input_data
    );

    modport master (
        output req0, req1, addr0, addr1, wmode0, wmode1, wdata0, wdata1,
        output ram_rdata, ram_done, ram_align_error,
        input  ack0, ack1, rdata, err,
        input  ram_address, ram_write_mode, ram_wdata,
        input  vga_write_en, vga_write_address, vga_input_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin arbiter for RAM and VGA write port
// Optional write-done timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int                   WORD_SIZE      = 32,
    parameter logic [WORD_SIZE-1:0] VGA_BASE       = 32'h00070000,
    parameter int                   RAM_RD_LATENCY = 2,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, WR_WAIT, VGA_WR, RESP} state_t;

    localparam logic [2:0] RD_CNT_INIT = 3'(RAM_RD_LATENCY - 1);

    state_t               state;
    state_t               state_next;
    logic                 last_grant;
    logic                 grant;
    logic                 grant_next;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [1:0]           wmode_q;
    logic [2:0]           rd_cnt;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 err_q;
    logic                 is_vga;
    logic                 is_write;
    logic                 wr_timeout;

    assign is_vga    = addr_q >= VGA_BASE;
    assign is_write  = wmode_q != 2'd0;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

`ifdef ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    assign wr_timeout = (state == WR_WAIT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != WR_WAIT) begin
            to_cnt <= '0;
        end else if (!bus.ram_done && !wr_timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign wr_timeout = 1'b0;
`endif

    always_comb begin
        state_next            = state;
        grant_next            = grant;
        bus.ack0              = 1'b0;
        bus.ack1              = 1'b0;
        bus.ram_address       = '0;
        bus.ram_write_mode    = 2'd0;
        bus.ram_wdata         = '0;
        bus.vga_write_en      = 1'b0;
        bus.vga_write_address = 13'd0;
        bus.vga_input_data    = '0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // on a tie the port that did not win last time goes first
                    grant_next = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (is_vga) begin
                    state_next = is_write ? VGA_WR : RESP;
                end else begin
                    bus.ram_address    = addr_q;
                    bus.ram_write_mode = wmode_q;
                    bus.ram_wdata      = is_write ? wdata_q : '0;
                    state_next         = is_write ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                bus.ram_address = addr_q;
                if (rd_cnt == 3'd0) state_next = RESP;
            end
            WR_WAIT: begin
                bus.ram_address = addr_q;
                bus.ram_wdata   = wdata_q;
                if (bus.ram_done || wr_timeout) begin
                    state_next = RESP;
                end else begin
                    bus.ram_write_mode = wmode_q;
                end
            end
            VGA_WR: begin
                bus.vga_write_en      = 1'b1;
                bus.vga_write_address = addr_q[12:0];
                bus.vga_input_data    = wdata_q;
                state_next            = RESP;
            end
            RESP: begin
                bus.ack0   = ~grant;
                bus.ack1   = grant;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmode_q    <= 2'd0;
            rd_cnt     <= 3'd0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (state_next == ISSUE) begin
                        grant      <= grant_next;
                        last_grant <= grant_next;
                        addr_q     <= grant_next ? bus.addr1 : bus.addr0;
                        wmode_q    <= grant_next ? bus.wmode1 : bus.wmode0;
                        wdata_q    <= grant_next ? bus.wdata1 : bus.wdata0;
                        err_q      <= 1'b0;
                    end
                end
                ISSUE: begin
                    rd_cnt <= RD_CNT_INIT;
                    // reads have no VGA read path
                    if (is_vga && !is_write) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == 3'd0) begin
                        rdata_q <= bus.ram_rdata;
                        err_q   <= bus.ram_align_error;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (bus.ram_done) begin
                        err_q <= bus.ram_align_error;
                    end else if (wr_timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with RAM environment model
module tb_mem_bus_arbiter;
    localparam logic [31:0] VGA_BASE = 32'h00070000;
    localparam int          RD_LAT   = 2;
    localparam int          TO_CYC   = 16;

    typedef struct {
        bit          port;
        bit          is_read;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  mode;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
    } vga_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;
    bit   model_last = 1'b1;
    bit   no_done = 1'b0;
    int   done_delay = -1;

    exp_t exp_q[$];
    wr_t  exp_wr_q[$];
    vga_t exp_vga_q[$];

    mem_bus_arbiter_if #(.WORD_SIZE(32)) bus ();

    mem_bus_arbiter #(
        .WORD_SIZE(32),
        .VGA_BASE(VGA_BASE),
        .RAM_RD_LATENCY(RD_LAT),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // contents of the simulated RAM
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] m);
        case (m)
            2'd2:    return a[0];
            2'd3:    return a[1:0] != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case (r[1:0])
            2'd0:    return {16'h0, r[17:2]};
            2'd1:    return VGA_BASE - 32'd4 + {29'h0, r[4:2]};
            2'd2:    return VGA_BASE + {19'h0, r[14:2]};
            default: return {16'hFFFF, r[17:2]};
        endcase
    endfunction

    // reference model: outcome of one transaction from the address map and mode alone
    task automatic expect_txn(input bit port, input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.is_read = (m == 2'd0);
        e.rdata = '0;
        e.err = 1'b0;
        if (a >= VGA_BASE) begin
            if (m == 2'd0) e.err = 1'b1;
            else exp_vga_q.push_back('{a[12:0], d});
        end else if (m == 2'd0) begin
            e.rdata = ram_word(a);
            e.err = (a[1:0] != 2'd0);
        end else begin
            e.err = no_done ? 1'b1 : misaligned(a, m);
            exp_wr_q.push_back('{a, m, d});
        end
        exp_q.push_back(e);
        model_last = port;
    endtask

    task automatic issue(input bit u0, input bit u1,
                         input logic [31:0] a0, input logic [1:0] m0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [1:0] m1, input logic [31:0] d1,
                         input bit mess);
        bit p0, p1;
        int cyc, exp_lat;
        logic [31:0] sa;
        logic [1:0] sm;
        @(negedge clk);
        if (u0 && u1) begin
            if (model_last) begin
                expect_txn(1'b0, a0, m0, d0);
                expect_txn(1'b1, a1, m1, d1);
            end else begin
                expect_txn(1'b1, a1, m1, d1);
                expect_txn(1'b0, a0, m0, d0);
            end
        end else if (u0) expect_txn(1'b0, a0, m0, d0);
        else expect_txn(1'b1, a1, m1, d1);
        exp_lat = 0;
        if (u0 ^ u1) begin
            sa = u0 ? a0 : a1;
            sm = u0 ? m0 : m1;
            if (sa >= VGA_BASE) exp_lat = (sm == 2'd0) ? 3 : 4;
            else if (sm == 2'd0) exp_lat = 3 + RD_LAT;
            else if (no_done) exp_lat = 3 + TO_CYC;
        end
        bus.req0 = u0; bus.addr0 = a0; bus.wmode0 = m0; bus.wdata0 = d0;
        bus.req1 = u1; bus.addr1 = a1; bus.wmode1 = m1; bus.wdata1 = d1;
        p0 = u0;
        p1 = u1;
        cyc = 1;
        while ((p0 || p1) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0) begin bus.req0 = 1'b0; p0 = 1'b0; end
            if (bus.ack1) begin bus.req1 = 1'b0; p1 = 1'b0; end
            // after the grant, inputs of the single active port are scrambled
            if (mess && (p0 || p1)) begin
                if (p0) begin
                    bus.addr0 = $urandom; bus.wdata0 = $urandom;
                    if ($urandom_range(0, 3) == 0) bus.req0 = 1'b0;
                end else begin
                    bus.addr1 = $urandom; bus.wdata1 = $urandom;
                    if ($urandom_range(0, 3) == 0) bus.req1 = 1'b0;
                end
            end
        end
        if (p0 || p1) begin
            chk("txn_timeout", {30'h0, p1, p0}, 32'h0);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end else if (exp_lat != 0) begin
            chk("latency", cyc, exp_lat);
        end
    endtask

    // RAM environment: read data RD_LAT cycles after address, write done after a delay
    logic [31:0] hist[RD_LAT];
    bit          wr_busy;
    int          wr_cnt;
    logic [31:0] wr_addr;
    logic [1:0]  wr_mode;
    wr_t         ram_w;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) hist[i] = '0;
            wr_busy = 1'b0;
            wr_cnt = 0;
            bus.ram_done = 1'b0;
            bus.ram_rdata = '0;
            bus.ram_align_error = 1'b0;
        end else begin
            if (bus.ram_done) begin
                bus.ram_done = 1'b0;
                wr_busy = 1'b0;
            end else if (wr_busy) begin
                if (wr_cnt == 0 && !no_done) bus.ram_done = 1'b1;
                else if (wr_cnt > 0) wr_cnt--;
            end else if (bus.ram_write_mode != 2'd0) begin
                wr_busy = 1'b1;
                wr_addr = bus.ram_address;
                wr_mode = bus.ram_write_mode;
                wr_cnt = (done_delay < 0) ? int'($urandom_range(0, 3)) : done_delay;
                if (exp_wr_q.size() == 0) begin
                    chk("spurious_ram_wr", {30'h0, bus.ram_write_mode}, 32'h0);
                end else begin
                    ram_w = exp_wr_q.pop_front();
                    chk("ram_wr_addr", bus.ram_address, ram_w.addr);
                    chk("ram_wr_mode", {30'h0, bus.ram_write_mode}, {30'h0, ram_w.mode});
                    chk("ram_wr_data", bus.ram_wdata, ram_w.data);
                end
            end
            bus.ram_align_error = wr_busy ? misaligned(wr_addr, wr_mode) : (hist[RD_LAT-1][1:0] != 2'd0);
            bus.ram_rdata = ram_word(hist[RD_LAT-1]);
            for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.ram_address;
        end
    end

    exp_t mon_e;
    vga_t mon_v;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.ack0 || bus.ack1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_port", {30'h0, bus.ack1, bus.ack0}, mon_e.port ? 32'h2 : 32'h1);
                    chk("ack_err", {31'h0, bus.err}, {31'h0, mon_e.err});
                    if (mon_e.is_read) chk("ack_rdata", bus.rdata, mon_e.rdata);
                end
            end
            if (bus.vga_write_en) begin
                if (exp_vga_q.size() == 0) begin
                    chk("spurious_vga", {31'h0, bus.vga_write_en}, 32'h0);
                end else begin
                    mon_v = exp_vga_q.pop_front();
                    chk("vga_addr", {19'h0, bus.vga_write_address}, {19'h0, mon_v.addr});
                    chk("vga_data", bus.vga_input_data, mon_v.data);
                    chk("vga_ram_mode", {30'h0, bus.ram_write_mode}, 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra0, ra1, rd0, rd1;
        logic [1:0]  rm0, rm1;
        int          sel;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.wmode0 = 2'd0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.wmode1 = 2'd0; bus.wdata1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        chk("rst_ram_address", bus.ram_address, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b1;

        issue(1, 0, 32'h10, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 1);
        done_delay = 0;
        issue(1, 1, 32'h20, 2'd3, 32'h11111111, 32'h24, 2'd3, 32'h22222222, 0);
        issue(1, 1, 32'h20, 2'd3, 32'h33333333, 32'h24, 2'd3, 32'h44444444, 0);
        issue(0, 1, 32'h0, 2'd0, 32'h0, 32'h00070005, 2'd1, 32'h41, 0);
        issue(1, 1, 32'h30, 2'd1, 32'h55, 32'h34, 2'd2, 32'h66, 0);
        issue(1, 0, 32'h00070000, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 0);
        issue(1, 0, 32'h0006FFFF, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 0);
        issue(1, 0, 32'h0006FFFC, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 0);
        issue(1, 0, 32'h3, 2'd3, 32'hCAFEF00D, 32'h0, 2'd0, 32'h0, 0);

        done_delay = -1;
        for (int n = 0; n < 60; n++) begin
            ra0 = rand_addr(); rm0 = 2'($urandom_range(0, 3)); rd0 = $urandom;
            ra1 = rand_addr(); rm1 = 2'($urandom_range(0, 3)); rd1 = $urandom;
            sel = $urandom_range(0, 2);
            issue(sel != 1, sel != 0, ra0, rm0, rd0, ra1, rm1, rd1, (sel != 2) && ($urandom_range(0, 1) == 1));
        end

        // reset in the middle of a RAM read
        issue(1, 0, 32'h44, 2'd0, 32'h0, 32'h0, 2'd0, 32'h0, 0);
        @(negedge clk);
        bus.req0 = 1'b1; bus.addr0 = 32'h100; bus.wmode0 = 2'd0;
        repeat (2) @(negedge clk);
        chk("mid_read_address", bus.ram_address, 32'h100);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ram_address", bus.ram_address, 32'h0);
        chk("async_rst_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        chk("async_rst_rdata", bus.rdata, 32'h0);
        chk("async_rst_err", {31'h0, bus.err}, 32'h0);
        chk("async_rst_vga", {31'h0, bus.vga_write_en}, 32'h0);
        bus.req0 = 1'b0;
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1, 1, 32'h200, 2'd0, 32'h0, 32'h204, 2'd0, 32'h0, 0);

`ifdef ARB_TIMEOUT_EN
        no_done = 1'b1;
        issue(1, 0, 32'h40, 2'd3, 32'h12345678, 32'h0, 2'd0, 32'h0, 0);
        chk("timeout_mode_dropped", {30'h0, bus.ram_write_mode}, 32'h0);
`endif

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'h0);
        chk("exp_wr_drained", exp_wr_q.size(), 32'h0);
        chk("exp_vga_drained", exp_vga_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
